n1_pbus_seq: RTL

Program bus sequencer for the N1 core. It drives the pipelined Wishbone master handshake on the program bus and handles stall, retry, error and timeout. It sequences the program bus AGU address register through the areg hold/select controls, and hands fetched words to the instruction register with a one-cycle registered strobe.

---
 rtl/n1_pbus_pkg.sv | 35 +++
 rtl/n1_pbus_seq_cnt.sv | 32 +++
 rtl/n1_pbus_seq.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/n1_pbus_pkg.sv
// Shared types for the N1 program bus sequencer: FSM states, response priority and counter width.
// The state encoding doubles as the value of the state probe output.
package n1_pbus_pkg;

  localparam int unsigned CntW = 8;

  typedef logic [CntW-1:0] cnt_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StErr  = 2'd3
  } seq_state_e;

  typedef enum logic [1:0] {
    RspNone = 2'd0,
    RspAck  = 2'd1,
    RspRty  = 2'd2,
    RspErr  = 2'd3
  } rsp_e;

  // Bus termination priority: err beats rty beats ack.
  function automatic rsp_e rsp_decode(input logic err, input logic rty, input logic ack);
    if (err) begin
      return RspErr;
    end else if (rty) begin
      return RspRty;
    end else if (ack) begin
      return RspAck;
    end
    return RspNone;
  endfunction

endpackage

// File: rtl/n1_pbus_seq_cnt.sv
// Loadable saturating counter with synchronous clear and equality compare.
// Used for both the retry count and the WAIT timeout.
module n1_pbus_seq_cnt
  import n1_pbus_pkg::*;
(
  input  logic clk_i,
  input  logic sync_rst_i,
  input  logic clr_i,
  input  logic load_i,
  input  cnt_t load_val_i,
  input  logic inc_i,
  input  cnt_t cmp_val_i,
  output cnt_t cnt_o,
  output logic eq_o
);

  cnt_t r_cnt;

  always_ff @(posedge clk_i) begin
    if (sync_rst_i || clr_i) begin
      r_cnt <= '0;
    end else if (load_i) begin
      r_cnt <= load_val_i;
    end else if (inc_i && (r_cnt != '1)) begin
      r_cnt <= r_cnt + cnt_t'(1);
    end
  end

  assign cnt_o = r_cnt;
  assign eq_o  = (r_cnt == cmp_val_i);

endmodule

// File: rtl/n1_pbus_seq.sv
// Program bus sequencer: pipelined Wishbone read master with stall, retry, error and timeout,
// steering the program AGU address register and strobing fetched words to the IR.
module n1_pbus_seq
  import n1_pbus_pkg::*;
#(
  parameter int unsigned RTY_MAX    = 3,
  parameter logic [7:0]  TMO_CYCLES = 8'd255
) (
  input  logic        clk_i,
  input  logic        sync_rst_i,
  output logic        pbus_cyc_o,
  output logic        pbus_stb_o,
  output logic        pbus_we_o,
  input  logic        pbus_ack_i,
  input  logic        pbus_stall_i,
  input  logic        pbus_err_i,
  input  logic        pbus_rty_i,
  input  logic [15:0] pbus_dat_i,
  input  logic        ir2seq_fetch_req_i,
  output logic        seq2ir_rdy_o,
  output logic [15:0] seq2ir_dat_o,
  output logic        seq2fc_busy_o,
  output logic        seq2pagu_areg_hold_o,
  output logic        seq2pagu_areg_sel_o,
  output logic        seq_err_o,
  input  logic        seq_err_clr_i,
  output logic [1:0]  prb_seq_state_o,
  output logic [7:0]  prb_seq_rty_cnt_o
);

  localparam cnt_t RtyMax  = cnt_t'(RTY_MAX);
  localparam cnt_t TmoLast = TMO_CYCLES - 8'd1;
  localparam logic TmoEn   = (TMO_CYCLES != 8'd0);

  seq_state_e  r_state;
  seq_state_e  w_state_d;
  logic        r_rdy;
  logic [15:0] r_dat;

  logic w_rsp_vld;
  rsp_e w_rsp;
  cnt_t w_rty_cnt;
  cnt_t w_tmo_cnt;
  logic w_rty_max;
  logic w_tmo_hit;
  logic w_rty_inc;
  logic w_rty_clr;
  logic w_tmo_inc;
  logic w_tmo_clr;
  logic w_hold;
  logic w_sel;

  // Responses only count once the strobe has been accepted.
  assign w_rsp_vld = ((r_state == StReq) && !pbus_stall_i) || (r_state == StWait);
  assign w_rsp     = w_rsp_vld ? rsp_decode(pbus_err_i, pbus_rty_i, pbus_ack_i) : RspNone;

  always_comb begin
    w_state_d = r_state;
    w_rty_inc = 1'b0;
    w_rty_clr = 1'b0;
    w_tmo_inc = 1'b0;
    w_hold    = 1'b1;
    w_sel     = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_hold = 1'b0;
        if (ir2seq_fetch_req_i) begin
          w_state_d = StReq;
        end
      end
      StReq, StWait: begin
        unique case (w_rsp)
          RspErr: w_state_d = StErr;
          RspRty: begin
            if (w_rty_max) begin
              w_state_d = StErr;
            end else begin
              // Reload the previous address for the retried fetch.
              w_state_d = StReq;
              w_rty_inc = 1'b1;
              w_hold    = 1'b0;
              w_sel     = 1'b1;
            end
          end
          RspAck: begin
            w_rty_clr = 1'b1;
            if (ir2seq_fetch_req_i) begin
              w_state_d = StReq;
              w_hold    = 1'b0;
            end else begin
              w_state_d = StIdle;
            end
          end
          RspNone: begin
            if (r_state == StReq) begin
              if (!pbus_stall_i) begin
                w_state_d = StWait;
              end
            end else if (TmoEn && w_tmo_hit) begin
              w_state_d = StErr;
            end else begin
              w_tmo_inc = 1'b1;
            end
          end
        endcase
      end
      StErr: begin
        if (seq_err_clr_i) begin
          w_state_d = StIdle;
          w_rty_clr = 1'b1;
        end
      end
    endcase
  end

  assign w_tmo_clr = (w_state_d != r_state);

  n1_pbus_seq_cnt u_rty_cnt (
    .clk_i      (clk_i),
    .sync_rst_i (sync_rst_i),
    .clr_i      (w_rty_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .inc_i      (w_rty_inc),
    .cmp_val_i  (RtyMax),
    .cnt_o      (w_rty_cnt),
    .eq_o       (w_rty_max)
  );

  n1_pbus_seq_cnt u_tmo_cnt (
    .clk_i      (clk_i),
    .sync_rst_i (sync_rst_i),
    .clr_i      (w_tmo_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .inc_i      (w_tmo_inc),
    .cmp_val_i  (TmoLast),
    .cnt_o      (w_tmo_cnt),
    .eq_o       (w_tmo_hit)
  );

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      r_state <= StIdle;
      r_rdy   <= 1'b0;
      r_dat   <= '0;
    end else begin
      r_state <= w_state_d;
      r_rdy   <= (w_rsp == RspAck);
      if (w_rsp == RspAck) begin
        r_dat <= pbus_dat_i;
      end
    end
  end

  assign pbus_cyc_o           = (r_state == StReq) || (r_state == StWait);
  assign pbus_stb_o           = (r_state == StReq);
  assign pbus_we_o            = 1'b0;
  assign seq2ir_rdy_o         = r_rdy;
  assign seq2ir_dat_o         = r_dat;
  assign seq2fc_busy_o        = pbus_cyc_o;
  assign seq2pagu_areg_hold_o = w_hold;
  assign seq2pagu_areg_sel_o  = w_sel;
  assign seq_err_o            = (r_state == StErr);
  assign prb_seq_state_o      = r_state;
  assign prb_seq_rty_cnt_o    = w_rty_cnt;

endmodule
